seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Scan controller for the four-digit seven-segment display path. It sequences the shared 4:1 nibble multiplexer by driving its 2-bit `sel`, and drives the matching active-low anode enables. Each anode goes dark for one dead cycle whenever the selected digit changes, which prevents ghosting. It also applies per-digit enable and blink masks, so game logic can hide or flash individual digits without touching the digit data.

## Interface
- `TICK_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be at least 2.
- `BLINK_DIV`, default 250: slot advances per blink half-period.
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `en`, in, 1: scan enable.
- `digit_mask`, in, 4: bit i = 1 lets digit i light.
- `blink_mask`, in, 4: bit i = 1 makes digit i blink.
- `sel`, out, 2: multiplexer select; 0 = digit 0 … 3 = digit 3.
- `an`, out, 4: anode enables, active-low; bit i drives digit i.
- `slot_tick`, out, 1: one-cycle pulse marking the first cycle of a new slot.
- `blink_phase`, out, 1: 1 = blinking digits blanked.

## Operation
- State:
  - prescaler `cnt`, width `$clog2(TICK_DIV)`, range 0..TICK_DIV-1
  - `sel`
  - blink counter `bcnt`, width `$clog2(BLINK_DIV)` (minimum 1), range 0..BLINK_DIV-1
  - `blink_phase`
  - registered `an` and `slot_tick`
- Reset values: `cnt`=0, `sel`=0, `bcnt`=0, `blink_phase`=0, `an`=4'b1111, `slot_tick`=0. Reset wins over every other input.
- **Advance condition**: `en`=1 and `cnt`=TICK_DIV-1. On an advance edge:
  - `cnt`<=0
  - `sel`<=`sel`+1, wrapping 3→0
  - `slot_tick`<=1
  - `an`<=4'b1111 (dead cycle)
- **Enabled, non-advance edge**:
  - `cnt`<=`cnt`+1
  - `slot_tick`<=0
  - `an`<=~onehot(`sel`) when the digit is lit, else 4'b1111.
  - The digit is lit when `digit_mask[sel]`=1 and !(`blink_mask[sel]` & `blink_phase`).
- **Blink**: on an advance edge, if `bcnt`=BLINK_DIV-1 then `bcnt`<=0 and `blink_phase` toggles; otherwise `bcnt`<=`bcnt`+1. `bcnt` and `blink_phase` never change on a non-advance edge.
- **`en`=0**:
  - `cnt`, `sel`, `bcnt` and `blink_phase` hold.
  - `an`<=4'b1111 and `slot_tick`<=0.
  - When `en` returns to 1, counting resumes from the held `cnt`, and `an` follows the normal rule from the next edge.
- At most one anode is low at any time. `an` is never low for a digit other than the current `sel`.

## Timing
- `sel` and `slot_tick` change on the same edge. `an` is 4'b1111 for exactly the first cycle of each slot (`cnt`=0, coinciding with `slot_tick`=1). The anode is active for the remaining TICK_DIV-1 cycles.
- Slot period is TICK_DIV cycles; full scan period is 4·TICK_DIV cycles.
- `blink_phase` period is 2·BLINK_DIV·TICK_DIV cycles.
- Mask changes reach `an` on the next non-dead edge (one-cycle latency).
- A `blink_phase` toggle takes effect on `an` at the edge after the dead cycle, i.e. from the first lit cycle of the new slot.
- Reset asserted mid-slot: the next edge forces all reset values regardless of `en` or the state of `cnt`.

## Test plan
- **Basic scan.** TICK_DIV=4, masks 4'b1111/4'b0000, `en`=1 after reset.
  - `sel` steps 0,1,2,3,0 every 4 cycles.
  - Per slot, `an` reads 1111 followed by three cycles of 1110, 1101, 1011, 0111 respectively.
  - `slot_tick` pulses once per slot, on the 1111 cycle.
- **Digit mask.** `digit_mask`=4'b0101.
  - `an` is 1110 in slot 0 and 1011 in slot 2.
  - `an` stays 1111 for the whole of slots 1 and 3.
  - `sel` still cycles 0..3.
- **Blink.** TICK_DIV=4, BLINK_DIV=2, `blink_mask`=4'b0001.
  - `blink_phase` toggles every 8 cycles.
  - Digit 0 is lit only in slots where `blink_phase`=0; digits 1-3 are unaffected.
- **Enable gating.** Drop `en` at `cnt`=2 of slot 1 for 5 cycles.
  - `an`=1111 and `sel`=1 throughout the gap.
  - After re-enable, `an`=1101 from the next edge.
  - The slot advances exactly 2 enabled cycles later (`cnt` 2→3→advance).
- **Wrap and reset mid-operation.**
  - Assert `reset` at `sel`=3, `cnt`=1 for one cycle: next cycle `sel`=0, `cnt`=0, `an`=1111, `slot_tick`=0, `blink_phase`=0.
  - Scanning then restarts from digit 0.
- **Exclusivity check.** Run 10000 cycles with random masks and `en`.
  - Assert `an` never has more than one zero bit.
  - Assert any zero bit is always at index `sel`.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: digit select, active-low anodes
// with a dead cycle per slot, and per-digit enable/blink masking.
module seg_scan_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int BLINK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] digit_mask,
    input  logic [3:0] blink_mask,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic       slot_tick,
    output logic       blink_phase
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [BW-1:0] bcnt;
    logic          advance;
    logic          lit;
    logic [3:0]    an_lit;

    // Slot boundary detect and the anode pattern for the current digit.
    always_comb begin
        advance = en && (cnt == CNT_MAX);
        lit     = digit_mask[sel] && !(blink_mask[sel] && blink_phase);
        an_lit  = lit ? ~(4'b0001 << sel) : 4'b1111;
    end

    // Prescaler, digit select, blink timebase and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            sel         <= 2'd0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
            an          <= 4'b1111;
            slot_tick   <= 1'b0;
        end else if (!en) begin
            an        <= 4'b1111;
            slot_tick <= 1'b0;
        end else if (advance) begin
            cnt       <= '0;
            sel       <= sel + 2'd1;
            slot_tick <= 1'b1;
            an        <= 4'b1111;
            if (bcnt == BCNT_MAX) begin
                bcnt        <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end else begin
            cnt       <= cnt + 1'b1;
            slot_tick <= 1'b0;
            an        <= an_lit;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=4, BLINK_DIV=2:
// scan order, masks, blink, enable gating, mid-slot reset, exclusivity.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] digit_mask;
    logic [3:0] blink_mask;
    logic [1:0] sel;
    logic [3:0] an;
    logic       slot_tick;
    logic       blink_phase;

    int vectors = 0;
    int miscompares = 0;

    seg_scan_ctrl #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .digit_mask(digit_mask),
        .blink_mask(blink_mask),
        .sel(sel),
        .an(an),
        .slot_tick(slot_tick),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] es,
                         input logic [3:0] ea, input logic et,
                         input logic eb);
        vectors++;
        assert ({sel, an, slot_tick, blink_phase} === {es, ea, et, eb})
        else begin
            miscompares++;
            $error("FAIL %s: sel=%0d an=%b tick=%b bp=%b, expected sel=%0d an=%b tick=%b bp=%b",
                   tag, sel, an, slot_tick, blink_phase, es, ea, et, eb);
        end
    endtask

    // Expected outputs k enabled edges after a reset edge (TICK_DIV=4,
    // BLINK_DIV=2): a slot starts every 4 edges, blink flips every 8.
    task automatic expect_k(input string tag, input int k);
        logic [1:0] s;
        logic       bp;
        logic       l;
        logic [3:0] a;
        s  = 2'((k / 4) % 4);
        bp = 1'((k / 8) % 2);
        if (k % 4 == 0) begin
            check(tag, s, 4'b1111, 1'b1, bp);
        end else begin
            l = digit_mask[s] && !(blink_mask[s] && bp);
            a = l ? ~(4'b0001 << s) : 4'b1111;
            check(tag, s, a, 1'b0, bp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset", 2'd0, 4'b1111, 1'b0, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        en         = 1'b1;
        digit_mask = 4'b1111;
        blink_mask = 4'b0000;

        // Basic scan, with literal spot checks on the first slots.
        do_reset();
        step(); check("scan_d0", 2'd0, 4'b1110, 1'b0, 1'b0);
        step(); check("scan_d0", 2'd0, 4'b1110, 1'b0, 1'b0);
        step(); check("scan_d0", 2'd0, 4'b1110, 1'b0, 1'b0);
        step(); check("scan_dead1", 2'd1, 4'b1111, 1'b1, 1'b0);
        step(); check("scan_d1", 2'd1, 4'b1101, 1'b0, 1'b0);
        for (int k = 6; k <= 20; k++) begin
            step();
            expect_k("scan", k);
        end

        // Digit mask: only digits 0 and 2 light.
        digit_mask = 4'b0101;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step();
            expect_k("dmask", k);
        end

        // Blink on digit 0.
        digit_mask = 4'b1111;
        blink_mask = 4'b0001;
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            step();
            expect_k("blink", k);
        end

        // Enable gating at cnt=2 of slot 1.
        blink_mask = 4'b0000;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step();
            expect_k("gate_pre", k);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("gate_off", 2'd1, 4'b1111, 1'b0, 1'b0);
        end
        en = 1'b1;
        step(); check("gate_resume", 2'd1, 4'b1101, 1'b0, 1'b0);
        step(); check("gate_adv", 2'd2, 4'b1111, 1'b1, 1'b1);
        step(); check("gate_next", 2'd2, 4'b1011, 1'b0, 1'b1);

        // Reset at sel=3, cnt=1 while blink_phase=1.
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            step();
            expect_k("pre_rst", k);
        end
        reset = 1'b1;
        en    = 1'b0;
        step();
        check("mid_rst", 2'd0, 4'b1111, 1'b0, 1'b0);
        reset = 1'b0;
        en    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            expect_k("post_rst", k);
        end

        // Random masks and enable: one anode at most, only at sel.
        for (int i = 0; i < 10000; i++) begin
            digit_mask = 4'($urandom_range(0, 15));
            blink_mask = 4'($urandom_range(0, 15));
            en         = ($urandom_range(0, 7) != 0);
            step();
            vectors++;
            assert (an === 4'b1111 || an === ~(4'b0001 << sel))
            else begin
                miscompares++;
                $error("FAIL excl: an=%b sel=%0d, expected 1111 or one-hot-low at sel",
                       an, sel);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
